ddr_fb_arbiter: RTL and testbench
=================================

// Module: ddr_fb_arbiter
// PURPOSE
//  Sequences and shares the DDR3 user command port between the camera write path and the HDMI read path of the
//  camera-to-HDMI frame buffer. Issues one BURST_BEATS burst at a time and generates per-frame buffer addresses.
//  Flips ping-pong buffers at frame boundaries. Sits between the CMOS/display FIFOs and the DDR3 controller app port.
// PARAMETERS
//  ADDR_W        28         app_addr width
//  BURST_BEATS   16         data beats per burst (one beat = one app data word)
//  BURST_INC     128        app_addr increment per burst
//  FRAME_BURSTS  7200       bursts per frame (1280x720, 8 px/beat)
//  FRAME_STRIDE  'h80_0000  app_addr distance between frame buffers
//  STARVE_MAX    4          consecutive read grants allowed while wr_req pending
// PORTS
//  clk             in   1       system clock; all logic single-domain
//  rst             in   1       asynchronous, active-high reset
//  calib_done      in   1       DDR init/calibration complete
//  wr_req          in   1       camera FIFO holds >= BURST_BEATS words
//  wr_frame_start  in   1       1-cycle pulse, camera frame begins (pre-synchronised to clk)
//  rd_req          in   1       display FIFO has room for >= BURST_BEATS words
//  rd_frame_start  in   1       1-cycle pulse, display frame begins (pre-synchronised)
//  app_cmd_en      out  1       command valid
//  app_cmd         out  3       3'b000 write, 3'b001 read
//  app_addr        out  ADDR_W  burst start address
//  app_cmd_rdy     in   1       controller accepts command when high with app_cmd_en
//  app_wdf_wren    out  1       write-data beat strobe
//  app_wdf_rdy     in   1       controller can take write data
//  cam_fifo_rd     out  1       pop camera FIFO (same cycle as beat consumed)
//  rd_data_valid   in   1       controller read-data beat strobe (data routed outside block)
//  wr_buf          out  2       buffer index being written
//  rd_buf          out  2       buffer index being read
//  busy            out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; wr_buf=rd_buf=done_buf=0; burst counters 0; starve counter 0; FSM IDLE.
//  FSM: IDLE, WR_CMD, WR_DATA, WR_DROP, RD_CMD, RD_WAIT. One burst outstanding max.
//  IDLE: calib_done low -> stay. Otherwise apply pending frame starts first, then arbitrate same cycle:
//   rd_req && !(wr_req && starve==STARVE_MAX) -> RD_CMD, starve+=1 if wr_req else starve=0;
//   else wr_req -> WR_CMD (or WR_DROP if wr_cnt==FRAME_BURSTS), starve=0.
//  WR_CMD/RD_CMD: app_cmd_en=1 from cycle after grant, held with stable app_cmd/app_addr until app_cmd_rdy.
//  app_addr = buf*FRAME_STRIDE + cnt*BURST_INC (ADDR_W bits, truncate).
//  WR_DATA: app_wdf_wren=cam_fifo_rd=app_wdf_rdy; after BURST_BEATS beats -> IDLE, wr_cnt+=1.
//  WR_DROP: frame overflow; no command; cam_fifo_rd=1 for BURST_BEATS cycles (discard) -> IDLE.
//  RD_WAIT: count rd_data_valid; after BURST_BEATS -> IDLE, rd_cnt+=1; rd_cnt wraps FRAME_BURSTS->0 (frame repeats).
//  rd_data_valid outside RD_WAIT ignored. app_wdf_rdy outside WR_DATA ignored.
//  Frame starts are latched as pending flags; applied only in IDLE (never mid-burst).
//   Write pending: if wr_cnt==FRAME_BURSTS then done_buf<=wr_buf, wr_buf<=next; wr_cnt<=0 always.
//   Read pending: rd_buf<=done_buf, rd_cnt<=0. Both pending in same IDLE cycle: write applied first.
//  Second frame-start pulse while already pending: merged (single event).
//  calib_done falling mid-burst: burst completes normally; FSM then holds IDLE.
// CONFIGURATION
//  FB_TRIPLE_BUF_EN defined: 3 buffers (0..2); next wr_buf = lowest index != done_buf and != rd_buf (tear-free).
//  Undefined: 2 buffers; next wr_buf = ~wr_buf[0]; wr_buf[1], rd_buf[1] tied 0; tearing permitted.
// STRUCTURE
//  Package fb_arb_pkg: FSM state enum, CMD_WR/CMD_RD encodings, buffer index typedef (2 bits).
//  Sub-module fb_buf_sel: combinational next-write-buffer selection (both macro variants).
// TESTING
//  Read starvation: rd_req=wr_req=1 held -> grant order R,R,R,R,W repeating (STARVE_MAX=4).
//  Write burst, app_wdf_rdy toggling 1/0 -> exactly 16 wdf_wren/cam_fifo_rd pulses; addr 0,128,256.
//  app_cmd_rdy low 5 cycles -> app_cmd_en, app_cmd, app_addr stable all 5 cycles.
//  wr_frame_start mid-WR_DATA after full frame -> wr_buf flips only after burst end; next write addr 'h80_0000.
//  Frame overflow (wr_cnt=7200, wr_req=1) -> WR_DROP, no app_cmd_en, 16 cam_fifo_rd pulses.
//  FB_TRIPLE_BUF_EN, done_buf=1, rd_buf=0, write frame done -> wr_buf=2; rd_frame_start -> rd_buf=done_buf.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types for the DDR3 frame-buffer arbiter: FSM states, app_cmd encodings, buffer index.
package fb_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_WR_DROP,
    ST_RD_CMD,
    ST_RD_WAIT
  } state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef logic [1:0] buf_idx_t;

endpackage

// File: rtl/fb_buf_sel.sv
// Next write-buffer selection at a write frame boundary.
// FB_TRIPLE_BUF_EN selects tear-free triple buffering; otherwise ping-pong between buffers 0 and 1.
module fb_buf_sel
  import fb_arb_pkg::*;
(
  input  buf_idx_t done_buf,
  input  buf_idx_t rd_buf,
  output buf_idx_t next_buf
);

`ifdef FB_TRIPLE_BUF_EN
  // Lowest buffer that is neither the frame just completed nor the one being displayed.
  always_comb begin
    next_buf = 2'd2;
    if (done_buf != 2'd0 && rd_buf != 2'd0) begin
      next_buf = 2'd0;
    end else if (done_buf != 2'd1 && rd_buf != 2'd1) begin
      next_buf = 2'd1;
    end
  end
`else
  logic unused_sel;

  assign next_buf   = {1'b0, ~done_buf[0]};
  assign unused_sel = ^{done_buf[1], rd_buf};
`endif

endmodule

// File: rtl/ddr_fb_arbiter.sv
// Shares the DDR3 app command port between the camera write path and the HDMI read path,
// one burst at a time, with per-frame buffer addressing. FB_TRIPLE_BUF_EN enables triple buffering.
module ddr_fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W       = 28,
  parameter int BURST_BEATS  = 16,
  parameter int BURST_INC    = 128,
  parameter int FRAME_BURSTS = 7200,
  parameter int FRAME_STRIDE = 'h80_0000,
  parameter int STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calib_done,
  input  logic              wr_req,
  input  logic              wr_frame_start,
  input  logic              rd_req,
  input  logic              rd_frame_start,
  output logic              app_cmd_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_cmd_rdy,
  output logic              app_wdf_wren,
  input  logic              app_wdf_rdy,
  output logic              cam_fifo_rd,
  input  logic              rd_data_valid,
  output logic [1:0]        wr_buf,
  output logic [1:0]        rd_buf,
  output logic              busy
);

  localparam int CNT_W    = $clog2(FRAME_BURSTS + 1);
  localparam int BEAT_W   = $clog2(BURST_BEATS);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0]    FRAME_FULL = CNT_W'(FRAME_BURSTS);
  localparam logic [CNT_W-1:0]    RD_LAST    = CNT_W'(FRAME_BURSTS - 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_BEATS - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  buf_idx_t            wr_buf_q, wr_buf_d;
  buf_idx_t            rd_buf_q, rd_buf_d;
  buf_idx_t            done_buf_q, done_buf_d;
  logic                wr_pend_q, wr_pend_d;
  logic                rd_pend_q, rd_pend_d;
  buf_idx_t            next_wr_buf;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;

  fb_buf_sel u_buf_sel (
    .done_buf (wr_buf_q),
    .rd_buf   (rd_buf_q),
    .next_buf (next_wr_buf)
  );

  assign wr_addr = ADDR_W'(32'(wr_buf_q) * 32'(FRAME_STRIDE) + 32'(wr_cnt_q) * 32'(BURST_INC));
  assign rd_addr = ADDR_W'(32'(rd_buf_q) * 32'(FRAME_STRIDE) + 32'(rd_cnt_q) * 32'(BURST_INC));

  // NOTE: flops update with non-blocking assignments only; all combinational blocks use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      beat_q     <= '0;
      starve_q   <= '0;
      wr_buf_q   <= '0;
      rd_buf_q   <= '0;
      done_buf_q <= '0;
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_q     <= beat_d;
      starve_q   <= starve_d;
      wr_buf_q   <= wr_buf_d;
      rd_buf_q   <= rd_buf_d;
      done_buf_q <= done_buf_d;
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  always_comb begin
    // NOTE: every *_d starts from its hold value so no branch can leave it unassigned (no latches).
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    beat_d     = beat_q;
    starve_d   = starve_q;
    wr_buf_d   = wr_buf_q;
    rd_buf_d   = rd_buf_q;
    done_buf_d = done_buf_q;
    wr_pend_d  = wr_pend_q | wr_frame_start;
    rd_pend_d  = rd_pend_q | rd_frame_start;

    unique case (state_q)
      ST_IDLE: begin
        if (calib_done) begin
          // Frame boundaries land here first so arbitration sees the post-boundary counters.
          if (wr_pend_q) begin
            wr_pend_d = wr_frame_start;
            if (wr_cnt_q == FRAME_FULL) begin
              done_buf_d = wr_buf_q;
              wr_buf_d   = next_wr_buf;
            end
            wr_cnt_d = '0;
          end
          if (rd_pend_q) begin
            rd_pend_d = rd_frame_start;
            rd_buf_d  = done_buf_d;
            rd_cnt_d  = '0;
          end
          if (rd_req && !(wr_req && starve_q == STARVE_LIM)) begin
            state_d  = ST_RD_CMD;
            starve_d = wr_req ? starve_q + 1'b1 : '0;
          end else if (wr_req) begin
            state_d  = (wr_cnt_d == FRAME_FULL) ? ST_WR_DROP : ST_WR_CMD;
            starve_d = '0;
          end
        end
      end
      ST_WR_CMD: if (app_cmd_rdy) state_d = ST_WR_DATA;
      ST_WR_DATA: begin
        if (app_wdf_rdy) begin
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            wr_cnt_d = wr_cnt_q + 1'b1;
            state_d  = ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_WR_DROP: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_RD_CMD: if (app_cmd_rdy) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (rd_data_valid) begin
          if (beat_q == LAST_BEAT) begin
            beat_d   = '0;
            rd_cnt_d = (rd_cnt_q == RD_LAST) ? '0 : rd_cnt_q + 1'b1;
            state_d  = ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    app_cmd_en   = 1'b0;
    app_cmd      = CMD_WR;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    cam_fifo_rd  = 1'b0;
    unique case (state_q)
      ST_WR_CMD: begin
        app_cmd_en = 1'b1;
        app_addr   = wr_addr;
      end
      ST_RD_CMD: begin
        app_cmd_en = 1'b1;
        app_cmd    = CMD_RD;
        app_addr   = rd_addr;
      end
      ST_WR_DATA: begin
        app_wdf_wren = app_wdf_rdy;
        cam_fifo_rd  = app_wdf_rdy;
      end
      ST_WR_DROP: cam_fifo_rd = 1'b1;
      default: ;
    endcase
  end

  assign wr_buf = wr_buf_q;
  assign rd_buf = rd_buf_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr_fb_arbiter.sv
// Self-checking bench for ddr_fb_arbiter: vector table of bursts plus frame-boundary and starvation sequences.
module tb_ddr_fb_arbiter;

  localparam int TB_FRAME_BURSTS = 3;

`ifdef FB_TRIPLE_BUF_EN
  localparam logic [1:0]  EXP_B      = 2'd2;
  localparam logic [27:0] EXP_B_ADDR = 28'h100_0000;
`else
  localparam logic [1:0]  EXP_B      = 2'd0;
  localparam logic [27:0] EXP_B_ADDR = 28'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        calib_done, wr_req, wr_frame_start, rd_req, rd_frame_start;
  logic        app_cmd_en, app_cmd_rdy, app_wdf_wren, app_wdf_rdy, cam_fifo_rd, rd_data_valid, busy;
  logic [2:0]  app_cmd;
  logic [27:0] app_addr;
  logic [1:0]  wr_buf, rd_buf;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [27:0] addr;
  } exp_cmd_t;

  typedef struct {
    bit          is_wr;
    bit          drop;
    int          cmd_delay;
    bit          toggle;
    bit          fs_mid;
    logic [27:0] exp_addr;
    logic [1:0]  exp_wr_buf;
  } vec_t;

  exp_cmd_t exp_q[$];
  exp_cmd_t mon_e;
  vec_t     tbl[11];
  int       checks = 0;
  int       errors = 0;
  int       wren_cnt = 0, fifo_cnt = 0, en_cycles = 0, hs_cnt = 0;

  ddr_fb_arbiter #(.FRAME_BURSTS(TB_FRAME_BURSTS)) dut (
    .clk            (clk),
    .rst            (rst),
    .calib_done     (calib_done),
    .wr_req         (wr_req),
    .wr_frame_start (wr_frame_start),
    .rd_req         (rd_req),
    .rd_frame_start (rd_frame_start),
    .app_cmd_en     (app_cmd_en),
    .app_cmd        (app_cmd),
    .app_addr       (app_addr),
    .app_cmd_rdy    (app_cmd_rdy),
    .app_wdf_wren   (app_wdf_wren),
    .app_wdf_rdy    (app_wdf_rdy),
    .cam_fifo_rd    (cam_fifo_rd),
    .rd_data_valid  (rd_data_valid),
    .wr_buf         (wr_buf),
    .rd_buf         (rd_buf),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor on the falling edge: pulse counters and command scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (app_cmd_en)   en_cycles++;
      if (app_wdf_wren) wren_cnt++;
      if (cam_fifo_rd)  fifo_cnt++;
      if (app_cmd_en && app_cmd_rdy) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'd0, 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_cmd", 32'(app_cmd), 32'(mon_e.cmd));
          check("sb_addr", 32'(app_addr), 32'(mon_e.addr));
        end
      end
    end
  end

  task automatic run_burst(input string tag, input bit is_wr, input bit drop, input int cmd_delay,
                           input bit toggle, input bit fs_mid, input logic [27:0] exp_addr);
    int n, w0, f0, e0;
    exp_cmd_t e;
    w0 = wren_cnt; f0 = fifo_cnt; e0 = en_cycles;
    if (!drop) begin
      e.cmd  = is_wr ? 3'b000 : 3'b001;
      e.addr = exp_addr;
      exp_q.push_back(e);
    end
    wr_req = is_wr; rd_req = !is_wr; app_cmd_rdy = 1'b0;
    cyc();
    wr_req = 1'b0; rd_req = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (!drop) begin
      for (int k = 0; k < cmd_delay; k++) begin
        check({tag, "_hold_en"}, 32'(app_cmd_en), 32'd1);
        check({tag, "_hold_cmd"}, 32'(app_cmd), 32'(e.cmd));
        check({tag, "_hold_addr"}, 32'(app_addr), 32'(exp_addr));
        cyc();
      end
      app_cmd_rdy = 1'b1;
      cyc();
      app_cmd_rdy = 1'b0;
    end
    n = 0;
    while (busy && n < 100) begin
      app_wdf_rdy    = is_wr ? (toggle ? ~n[0] : 1'b1) : 1'b1;
      rd_data_valid  = is_wr ? 1'b1 : (toggle ? ~n[0] : 1'b1);
      wr_frame_start = fs_mid && (n == 4);
      cyc();
      n++;
    end
    app_wdf_rdy = 1'b0; rd_data_valid = 1'b0; wr_frame_start = 1'b0;
    check({tag, "_data_cycles"}, 32'(n), toggle ? 32'd31 : 32'd16);
    check({tag, "_wren_pulses"}, 32'(wren_cnt - w0), (is_wr && !drop) ? 32'd16 : 32'd0);
    check({tag, "_fifo_rd_pulses"}, 32'(fifo_cnt - f0), is_wr ? 32'd16 : 32'd0);
    check({tag, "_cmd_en_cycles"}, 32'(en_cycles - e0), drop ? 32'd0 : 32'(cmd_delay + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hs0, wcnt, rcnt;
    exp_cmd_t e;

    //           wr drop dly tog fs  addr          wr_buf after
    tbl[0]  = '{1, 0, 0, 1, 0, 28'h0,        2'd0};
    tbl[1]  = '{1, 0, 5, 0, 0, 28'h80,       2'd0};
    tbl[2]  = '{0, 0, 0, 1, 0, 28'h0,        2'd0};
    tbl[3]  = '{1, 0, 2, 1, 1, 28'h100,      2'd0};
    tbl[4]  = '{1, 0, 0, 0, 0, 28'h80_0000,  2'd1};
    tbl[5]  = '{0, 0, 1, 0, 0, 28'h80,       2'd1};
    tbl[6]  = '{0, 0, 0, 0, 0, 28'h100,      2'd1};
    tbl[7]  = '{0, 0, 0, 0, 0, 28'h0,        2'd1};
    tbl[8]  = '{1, 0, 0, 1, 0, 28'h80_0080,  2'd1};
    tbl[9]  = '{1, 0, 3, 0, 0, 28'h80_0100,  2'd1};
    tbl[10] = '{1, 1, 0, 0, 0, 28'h0,        2'd1};

    rst = 1'b1; calib_done = 1'b0; wr_req = 1'b0; wr_frame_start = 1'b0;
    rd_req = 1'b0; rd_frame_start = 1'b0; app_cmd_rdy = 1'b0; app_wdf_rdy = 1'b0;
    rd_data_valid = 1'b0;
    repeat (3) cyc();
    check("rst_cmd_en", 32'(app_cmd_en), 32'd0);
    check("rst_cmd", 32'(app_cmd), 32'd0);
    check("rst_addr", 32'(app_addr), 32'd0);
    check("rst_wren", 32'(app_wdf_wren), 32'd0);
    check("rst_fifo_rd", 32'(cam_fifo_rd), 32'd0);
    check("rst_wr_buf", 32'(wr_buf), 32'd0);
    check("rst_rd_buf", 32'(rd_buf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // No grants before calibration completes.
    wr_req = 1'b1; rd_req = 1'b1;
    repeat (4) begin
      cyc();
      check("calib_low_idle", 32'(busy), 32'd0);
    end
    wr_req = 1'b0; rd_req = 1'b0; calib_done = 1'b1;
    cyc();

    for (int i = 0; i < 11; i++) begin
      run_burst($sformatf("v%0d", i), tbl[i].is_wr, tbl[i].drop, tbl[i].cmd_delay,
                tbl[i].toggle, tbl[i].fs_mid, tbl[i].exp_addr);
      check($sformatf("v%0d_wr_buf", i), 32'(wr_buf), 32'(tbl[i].exp_wr_buf));
      check($sformatf("v%0d_rd_buf", i), 32'(rd_buf), 32'd0);
    end

    // Frame starts held pending while calibration is low; both applied together, write first.
    calib_done = 1'b0;
    wr_frame_start = 1'b1; rd_frame_start = 1'b1;
    cyc();
    wr_frame_start = 1'b0; rd_frame_start = 1'b0;
    cyc();
    wr_frame_start = 1'b1;
    cyc();
    wr_frame_start = 1'b0;
    cyc();
    check("pend_hold_wr_buf", 32'(wr_buf), 32'd1);
    check("pend_hold_rd_buf", 32'(rd_buf), 32'd0);
    calib_done = 1'b1;
    cyc();
    check("pend_apply_wr_buf", 32'(wr_buf), 32'(EXP_B));
    check("pend_apply_rd_buf", 32'(rd_buf), 32'd1);
    cyc();
    check("pend_merged_wr_buf", 32'(wr_buf), 32'(EXP_B));
    run_burst("h1_rd", 1'b0, 1'b0, 0, 1'b0, 1'b0, 28'h80_0000);
    run_burst("h1_wr", 1'b1, 1'b0, 0, 1'b0, 1'b0, EXP_B_ADDR);

    // Starvation: both requests held, expect R,R,R,R,W repeating.
    rcnt = 1; wcnt = 1;
    for (int g = 0; g < 10; g++) begin
      if (g % 5 == 4) begin
        e.cmd = 3'b000; e.addr = EXP_B_ADDR + 28'(wcnt * 128); wcnt++;
      end else begin
        e.cmd = 3'b001; e.addr = 28'h80_0000 + 28'(rcnt * 128); rcnt = (rcnt + 1) % 3;
      end
      exp_q.push_back(e);
    end
    hs0 = hs_cnt;
    wr_req = 1'b1; rd_req = 1'b1; app_cmd_rdy = 1'b1; app_wdf_rdy = 1'b1; rd_data_valid = 1'b1;
    n = 0;
    while ((hs_cnt - hs0) < 10 && n < 2000) begin
      cyc();
      n++;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("starve_grants", 32'(hs_cnt - hs0), 32'd10);
    n = 0;
    while (busy && n < 100) begin
      cyc();
      n++;
    end
    app_cmd_rdy = 1'b0; app_wdf_rdy = 1'b0; rd_data_valid = 1'b0;
    check("starve_idle", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
